// File: rtl/rip_axi_read_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rip_axi_read_arbiter_pkg
// Shared AXI constants for the read arbiter slice: burst and response
// encodings plus the requester count. No ports; imported by the arbiter files.
// ----------------------------------------------------------------------------
package rip_axi_read_arbiter_pkg;

   typedef enum logic [1:0] {
      AXI_BURST_FIXED = 2'b00,
      AXI_BURST_INCR  = 2'b01,
      AXI_BURST_WRAP  = 2'b10,
      AXI_BURST_RSVD  = 2'b11
   } axi_burst_t;

   typedef enum logic [1:0] {
      AXI_RESP_OKAY   = 2'b00,
      AXI_RESP_EXOKAY = 2'b01,
      AXI_RESP_SLVERR = 2'b10,
      AXI_RESP_DECERR = 2'b11
   } axi_resp_t;

   localparam int NUM_REQ = 2;

endpackage

// File: rtl/rip_axi_read_arbiter_rr.sv
// ----------------------------------------------------------------------------
// rip_rr_arbiter2
// Two-way round-robin arbiter with a last-grant register.
//   clk, rst    : clock, synchronous active-high reset
//   i_req[1:0]  : request vector (index 0 = instruction fetch, 1 = data)
//   i_en        : commit the current grant into the last-grant register
//   o_valid     : at least one request present
//   o_grant     : index of the winning requester (valid when o_valid)
// ----------------------------------------------------------------------------
module rip_rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] i_req,
   input  logic       i_en,
   output logic       o_valid,
   output logic       o_grant
);

   // Resets to 1 so requester 0 wins the first tie after reset.
   logic r_last_grant;

   always_comb begin
      o_valid = |i_req;
      if (i_req == 2'b11) begin
         o_grant = ~r_last_grant;
      end else begin
         // Single (or no) requester: req0 alone -> 0, otherwise 1.
         o_grant = ~i_req[0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= 1'b1;
      end else if (i_en && o_valid) begin
         r_last_grant <= o_grant;
      end
   end

endmodule

// File: rtl/rip_axi_read_arbiter.sv
// ----------------------------------------------------------------------------
// rip_axi_read_arbiter
// Arbitrates two AXI read requesters (0 = instruction fetch, 1 = data) onto
// one AXI read master with a single transaction outstanding at a time.
//   clk, rst                      : clock, synchronous active-high reset
//   s_arvalid/s_arready[1:0]      : per-requester AR handshake
//   s_araddr/s_arlen/s_arburst    : per-requester AR fields, packed [1]..[0]
//   s_rvalid[1:0]/s_rready[1:0]   : per-requester R handshake
//   s_rdata/s_rresp/s_rlast       : shared R payload (pass-through)
//   m_ar*                         : AR channel toward the memory side
//   m_r*                          : R channel from the memory side
//   o_dbg_state                   : FSM state (0 IDLE, 1 ADDR, 2 DATA)
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; valid, once raised, holds its payload until that edge.
// ----------------------------------------------------------------------------
module rip_axi_read_arbiter
   import rip_axi_read_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              s_arvalid,
   output logic [1:0]              s_arready,
   input  logic [2*ADDR_WIDTH-1:0] s_araddr,
   input  logic [15:0]             s_arlen,
   input  logic [3:0]              s_arburst,
   output logic [1:0]              s_rvalid,
   input  logic [1:0]              s_rready,
   output logic [DATA_WIDTH-1:0]   s_rdata,
   output axi_resp_t               s_rresp,
   output logic                    s_rlast,
   output logic                    m_arvalid,
   input  logic                    m_arready,
   output logic [ADDR_WIDTH-1:0]   m_araddr,
   output logic [7:0]              m_arlen,
   output axi_burst_t              m_arburst,
   output logic [ID_WIDTH-1:0]     m_arid,
   input  logic                    m_rvalid,
   output logic                    m_rready,
   input  logic [DATA_WIDTH-1:0]   m_rdata,
   input  axi_resp_t               m_rresp,
   input  logic                    m_rlast,
   input  logic [ID_WIDTH-1:0]     m_rid,
   output logic [1:0]              o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  r_grant;
   logic [ADDR_WIDTH-1:0] r_araddr;
   logic [7:0]            r_arlen;
   axi_burst_t            r_arburst;

   logic                  w_arb_valid;
   logic                  w_arb_grant;
   logic                  w_arb_en;
   logic                  w_take;

   // Arbitration only advances when a new transaction is accepted.
   assign w_arb_en = (r_state == ST_IDLE);
   assign w_take   = w_arb_en && w_arb_valid;

   rip_rr_arbiter2 u_rr (
      .clk     (clk),
      .rst     (rst),
      .i_req   (s_arvalid),
      .i_en    (w_arb_en),
      .o_valid (w_arb_valid),
      .o_grant (w_arb_grant)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_grant   <= 1'b0;
         r_araddr  <= '0;
         r_arlen   <= '0;
         r_arburst <= AXI_BURST_FIXED;
      end else begin
         r_state <= w_next;
         if (w_take) begin
            r_grant   <= w_arb_grant;
            r_araddr  <= w_arb_grant ? s_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                     : s_araddr[ADDR_WIDTH-1:0];
            r_arlen   <= w_arb_grant ? s_arlen[15:8] : s_arlen[7:0];
            r_arburst <= axi_burst_t'(w_arb_grant ? s_arburst[3:2]
                                                  : s_arburst[1:0]);
         end
      end
   end

   always_comb begin
      w_next    = r_state;
      m_arvalid = 1'b0;
      s_arready = 2'b00;
      m_rready  = 1'b0;
      s_rvalid  = 2'b00;
      case (r_state)
         ST_IDLE: begin
            if (w_arb_valid) begin
               w_next = ST_ADDR;
            end
         end
         ST_ADDR: begin
            m_arvalid = 1'b1;
            // The requester only sees its AR accepted when the master does.
            if (m_arready) begin
               s_arready[r_grant] = 1'b1;
               w_next             = ST_DATA;
            end
         end
         ST_DATA: begin
            s_rvalid[r_grant] = m_rvalid;
            m_rready          = s_rready[r_grant];
            if (m_rvalid && s_rready[r_grant] && m_rlast) begin
               w_next = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   assign m_araddr    = r_araddr;
   assign m_arlen     = r_arlen;
   assign m_arburst   = r_arburst;
   assign m_arid      = ID_WIDTH'(r_grant);
   assign o_dbg_state = r_state;

   // R payload is a straight pass-through; a beat carrying a foreign ID is
   // still delivered but flagged as a slave error.
   assign s_rdata = m_rdata;
   assign s_rlast = m_rlast;
   assign s_rresp = (m_rid == m_arid) ? m_rresp : AXI_RESP_SLVERR;

endmodule
